// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART with fixed clocks-per-bit timing.
// Optional even parity bit on both directions when UART_TOP_PARITY_EN is defined.
module uart_top #(
    parameter int SIZE       = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_COUNT = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] data_in,
    input  logic            tx_en,
    input  logic            rx,
    output logic            tx,
    output logic            tx_busy,
    output logic [SIZE-1:0] data_out,
    output logic            rx_done
);

    localparam int CW = $clog2(BAUD_COUNT);
    localparam int BW = $clog2(SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(BAUD_COUNT / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);

    if (BAUD_COUNT < 4 || SIZE < 2 || CLK_FREQ < BAUD_RATE) begin : g_cfg_check
        $error("uart_top: unsupported configuration");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [BW-1:0]   tx_bit, tx_bit_n;
    logic [SIZE-1:0] tx_sh, tx_sh_n;
    logic            tx_n, tx_busy_n, tx_last;
`ifdef UART_TOP_PARITY_EN
    logic            tx_par, tx_par_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_TOP_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx       <= tx_n;
            tx_busy  <= tx_busy_n;
`ifdef UART_TOP_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    assign tx_last = (tx_cnt == CNT_LAST);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_last ? '0 : tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_n       = tx;
        tx_busy_n  = tx_busy;
`ifdef UART_TOP_PARITY_EN
        tx_par_n   = tx_par;
`endif
        unique case (tx_state)
            S_IDLE: begin
                tx_cnt_n  = '0;
                tx_n      = 1'b1;
                tx_busy_n = 1'b0;
                if (tx_en) begin
                    tx_sh_n    = data_in;
                    tx_state_n = S_START;
                    tx_n       = 1'b0;
                    tx_busy_n  = 1'b1;
`ifdef UART_TOP_PARITY_EN
                    tx_par_n   = ^data_in;
`endif
                end
            end
            S_START: if (tx_last) begin
                tx_state_n = S_DATA;
                tx_bit_n   = '0;
                tx_n       = tx_sh[0];
            end
            S_DATA: if (tx_last) begin
                // word is shifted out LSB first; bit 1 becomes the next line value
                tx_sh_n = tx_sh >> 1;
                if (tx_bit == BIT_LAST) begin
`ifdef UART_TOP_PARITY_EN
                    tx_state_n = S_PARITY;
                    tx_n       = tx_par;
`else
                    tx_state_n = S_STOP;
                    tx_n       = 1'b1;
`endif
                end else begin
                    tx_bit_n = tx_bit + 1'b1;
                    tx_n     = tx_sh[1];
                end
            end
            S_PARITY: if (tx_last) begin
                tx_state_n = S_STOP;
                tx_n       = 1'b1;
            end
            S_STOP: if (tx_last) begin
                tx_state_n = S_IDLE;
                tx_busy_n  = 1'b0;
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    state_t          rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [BW-1:0]   rx_bit, rx_bit_n;
    logic [SIZE-1:0] rx_sh, rx_sh_n, data_out_n;
    logic            rx_q, rx_done_n, rx_last, rx_good;
`ifdef UART_TOP_PARITY_EN
    logic            rx_par_ok, rx_par_ok_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q     <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            data_out <= '0;
            rx_done  <= 1'b0;
`ifdef UART_TOP_PARITY_EN
            rx_par_ok <= 1'b0;
`endif
        end else begin
            rx_q     <= rx;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            data_out <= data_out_n;
            rx_done  <= rx_done_n;
`ifdef UART_TOP_PARITY_EN
            rx_par_ok <= rx_par_ok_n;
`endif
        end
    end

    assign rx_last = (rx_cnt == CNT_LAST);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_last ? '0 : rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        data_out_n = data_out;
        rx_done_n  = 1'b0;
`ifdef UART_TOP_PARITY_EN
        rx_par_ok_n = rx_par_ok;
        rx_good     = rx_q && rx_par_ok;
`else
        rx_good     = rx_q;
`endif
        unique case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                // only reached with the line high, so a low sample is a falling edge
                if (!rx_q) rx_state_n = S_START;
            end
            S_START: if (rx_cnt == CNT_MID) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_last) begin
                rx_sh_n = {rx_q, rx_sh[SIZE-1:1]};
                if (rx_bit == BIT_LAST) begin
`ifdef UART_TOP_PARITY_EN
                    rx_state_n = S_PARITY;
`else
                    rx_state_n = S_STOP;
`endif
                end else begin
                    rx_bit_n = rx_bit + 1'b1;
                end
            end
            S_PARITY: if (rx_last) begin
`ifdef UART_TOP_PARITY_EN
                rx_par_ok_n = (rx_q == ^rx_sh);
`endif
                rx_state_n = S_STOP;
            end
            S_STOP: if (rx_last) begin
                if (rx_good) begin
                    data_out_n = rx_sh;
                    rx_done_n  = 1'b1;
                end
                rx_state_n = rx_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                rx_cnt_n = '0;
                if (rx_q) rx_state_n = S_IDLE;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_top.sv
// Loopback bench for uart_top: scoreboard queue of expected received words.
module tb_uart_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       tx_en = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loopback = 1'b1;
    logic       rx_w;
    logic       tx, tx_busy, rx_done;
    logic [7:0] data_out;

    int n_pass = 0, n_total = 0;
    int cyc = 0, rx_count = 0, done_cyc = 0;
    logic [7:0] exp_q[$];

    assign rx_w = loopback ? tx : rx_drv;

    uart_top #(.SIZE(8), .BAUD_RATE(115200), .CLK_FREQ(1000000), .BAUD_COUNT(9)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .tx_en(tx_en), .rx(rx_w),
        .tx(tx), .tx_busy(tx_busy), .data_out(data_out), .rx_done(rx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // receive-side scoreboard
    always @(negedge clk) begin
        if (!rst && rx_done === 1'b1) begin
            rx_count++;
            done_cyc = cyc;
            if (exp_q.size() == 0) chk("rx_unexpected", exp_q.size(), 1);
            else chk("rx_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_rx(input int n, input string tag);
        int k = 0;
        while (rx_count < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, rx_count, n);
    endtask

    task automatic send_raw(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (9) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] words[100];
        logic [7:0] rebuilt;
        int e_cyc, lat, n, base;
        logic any_busy;

        // reset held for 10 clocks
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_state", {tx, tx_busy, data_out, rx_done}, {1'b1, 1'b0, 8'h00, 1'b0});
        end
        rst = 1'b0;

        // single 0xA5 loopback frame
        @(negedge clk);
        frame = {1'b1, 8'hA5, 1'b0};
        data_in = 8'hA5; tx_en = 1'b1; exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        e_cyc = cyc; tx_en = 1'b0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            chk("a5_tx_bit", tx, frame[k/9]);
            chk("a5_busy", tx_busy, 1);
        end
        @(negedge clk);
        chk("a5_end", {tx, tx_busy}, 2'b10);
        wait_rx(1, "a5_rx_count");
        lat = done_cyc - e_cyc;
        chk("a5_latency", (lat >= 85 && lat <= 93), 1);

        // 100 random words back-to-back
        base = rx_count;
        foreach (words[i]) words[i] = 8'($urandom);
        @(negedge clk);
        data_in = words[0]; tx_en = 1'b1; exp_q.push_back(words[0]);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("b2b_accept", tx_busy, 1);
            if (i < 99) begin
                data_in = words[i+1];
                exp_q.push_back(words[i+1]);
            end
            n = 0;
            do begin
                @(negedge clk);
                if (tx_busy) n++;
            end while (tx_busy && n < 200);
            chk("b2b_frame_len", n, 90);
            if (i == 99) tx_en = 1'b0;
        end
        wait_rx(base + 100, "b2b_rx_count");

        // tx_en during a frame is ignored
        base = rx_count;
        @(negedge clk);
        data_in = 8'h3C; tx_en = 1'b1; exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        tx_en = 1'b0;
        rebuilt = '0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (k == 30) begin data_in = 8'hFF; tx_en = 1'b1; end
            if (k == 36) tx_en = 1'b0;
            if (k % 9 == 4 && k / 9 >= 1 && k / 9 <= 8) rebuilt[k/9 - 1] = tx;
        end
        chk("guard_tx_word", rebuilt, 8'h3C);
        any_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            any_busy |= tx_busy;
        end
        chk("guard_no_second", any_busy, 0);
        wait_rx(base + 1, "guard_rx_count");

        // framing error and glitch, rx driven directly
        loopback = 1'b0;
        base = rx_count;
        send_raw({1'b0, 8'h55, 1'b0});
        repeat (30) @(negedge clk);
        chk("framing_no_done", rx_count, base);
        chk("framing_dout", data_out, 8'h3C);
        exp_q.push_back(8'h96);
        send_raw({1'b1, 8'h96, 1'b0});
        wait_rx(base + 1, "recover_rx_count");
        base = rx_count;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (120) @(negedge clk);
        chk("glitch_no_done", rx_count, base);
        chk("glitch_dout", data_out, 8'h96);

        // reset in the middle of a 0x81 frame
        loopback = 1'b1;
        @(negedge clk);
        data_in = 8'h81; tx_en = 1'b1;
        @(posedge clk); #1;
        tx_en = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx_busy", {tx, tx_busy}, 2'b10);
        chk("abort_dout", data_out, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_no_done", rx_count, base);
        exp_q.push_back(8'h81);
        data_in = 8'h81; tx_en = 1'b1;
        @(posedge clk); #1;
        tx_en = 1'b0;
        wait_rx(base + 1, "after_reset_rx_count");

        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
